// File: rtl/hmac_pkg.sv
// Shared constants and controller state encoding for the HMAC word loader.
package hmac_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned RATE_W    = 1088;
  localparam int unsigned MAC_W     = 256;
  localparam int unsigned KEY_WORDS = RATE_W / WORD_W;
  localparam int unsigned MAC_WORDS = MAC_W / WORD_W;

  typedef enum logic [2:0] {
    LOAD_KEY,
    LOAD_MSG,
    CLR,
    START,
    WAIT,
    DRAIN
  } state_e;

endpackage

// File: rtl/word_packer.sv
// MSB-first packer: word k of a block lands at block[RATE_W-1-WORD_W*k -: WORD_W].
module word_packer #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned RATE_W = 1088,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [WORD_W-1:0] data,
  output logic [RATE_W-1:0] block,
  output logic [CNT_W-1:0]  count,
  output logic              full
);

  localparam int unsigned NumWords = RATE_W / WORD_W;
  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(NumWords - 1);

  logic [RATE_W-1:0] block_q, block_d;
  logic [CNT_W-1:0]  count_q, count_d;

  assign full  = load && (count_q == LastIdx);
  assign block = block_q;
  assign count = count_q;

  always_comb begin
    block_d = block_q;
    count_d = count_q;
    for (int i = 0; i < NumWords; i++) begin
      if (load && (count_q == CNT_W'(i))) begin
        block_d[RATE_W-1-WORD_W*i -: WORD_W] = data;
      end
    end
    if (load) begin
      count_d = full ? '0 : count_q + 1'b1;
    end
    // The packed block survives a soft clear; only the position restarts.
    if (clr) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      block_q <= '0;
      count_q <= '0;
    end else begin
      block_q <= block_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/hmac_word_loader.sv
// Streams key and message blocks into the HMAC core, sequences clear/start,
// and serializes the resulting MAC onto a word stream.
module hmac_word_loader #(
  parameter int unsigned WORD_W  = hmac_pkg::WORD_W,
  parameter int unsigned RATE_W  = hmac_pkg::RATE_W,
  parameter int unsigned MAC_W   = hmac_pkg::MAC_W,
  parameter int unsigned TIMEOUT = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              hmac_rst_n,
  output logic              hmac_start,
  output logic [RATE_W-1:0] hmac_key,
  output logic [RATE_W-1:0] hmac_msg,
  input  logic              hmac_ready,
  input  logic [MAC_W-1:0]  hmac_mac,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              err
);
  import hmac_pkg::*;

  localparam int unsigned CntW     = 6;
  localparam int unsigned ToW      = $clog2(TIMEOUT + 1);
  localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] MacLast = CntW'(MAC_W / WORD_W - 1);

  state_e            state_q, state_d;
  logic [ToW-1:0]    timer_q, timer_d;
  logic [CntW-1:0]   out_cnt_q, out_cnt_d;
  logic              ready_prev_q, ready_prev_d;
  logic              err_q, err_d;
  logic [MAC_W-1:0]  mac_sr_q, mac_sr_d;

  logic              key_load, msg_load, key_full, msg_full;
  logic [CntW-1:0]   key_count, msg_count;

  assign in_ready = ((state_q == LOAD_KEY) || (state_q == LOAD_MSG)) && !clr;
  assign key_load = in_valid && in_ready && (state_q == LOAD_KEY);
  assign msg_load = in_valid && in_ready && (state_q == LOAD_MSG);

  word_packer #(.WORD_W(WORD_W), .RATE_W(RATE_W), .CNT_W(CntW)) u_key_packer (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .load  (key_load),
    .data  (in_data),
    .block (hmac_key),
    .count (key_count),
    .full  (key_full)
  );

  word_packer #(.WORD_W(WORD_W), .RATE_W(RATE_W), .CNT_W(CntW)) u_msg_packer (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .load  (msg_load),
    .data  (in_data),
    .block (hmac_msg),
    .count (msg_count),
    .full  (msg_full)
  );

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    out_cnt_d    = out_cnt_q;
    ready_prev_d = ready_prev_q;
    err_d        = err_q;
    mac_sr_d     = mac_sr_q;
    unique case (state_q)
      LOAD_KEY: if (key_full) state_d = LOAD_MSG;
      LOAD_MSG: if (msg_full) state_d = CLR;
      CLR: begin
        state_d = START;
        timer_d = '0;
      end
      START: begin
        if (timer_q == ToW'(1)) begin
          state_d      = WAIT;
          timer_d      = '0;
          ready_prev_d = 1'b0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT: begin
        ready_prev_d = hmac_ready;
        if (hmac_ready && !ready_prev_q) begin
          mac_sr_d  = hmac_mac;
          out_cnt_d = '0;
          state_d   = DRAIN;
        end else if (timer_q == ToLast) begin
          err_d   = 1'b1;
          state_d = LOAD_KEY;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          mac_sr_d  = mac_sr_q << WORD_W;
          out_cnt_d = out_cnt_q + 1'b1;
          if (out_cnt_q == MacLast) state_d = LOAD_KEY;
        end
      end
      default: state_d = LOAD_KEY;
    endcase
    if (clr) begin
      state_d   = LOAD_KEY;
      timer_d   = '0;
      out_cnt_d = '0;
      err_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LOAD_KEY;
      timer_q      <= '0;
      out_cnt_q    <= '0;
      ready_prev_q <= 1'b0;
      err_q        <= 1'b0;
      mac_sr_q     <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      out_cnt_q    <= out_cnt_d;
      ready_prev_q <= ready_prev_d;
      err_q        <= err_d;
      mac_sr_q     <= mac_sr_d;
    end
  end

  assign hmac_rst_n = (state_q != CLR);
  assign hmac_start = (state_q == START);
  assign out_valid  = (state_q == DRAIN);
  assign out_data   = mac_sr_q[MAC_W-1 -: WORD_W];
  // msg_count is always zero in LOAD_KEY; folded in to keep both counts observed.
  assign busy       = !((state_q == LOAD_KEY) && (key_count == '0) && (msg_count == '0));
  assign err        = err_q;

endmodule
